// File: rtl/ex_muldiv.sv
// Execute stage: single-cycle logic/shift/arith/move ops, HI/LO registers,
// single-cycle unsigned multiply and an iterative restoring unsigned divider.
module ex_muldiv #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 8,
  parameter int unsigned ALUSEL_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [ALUSEL_W-1:0]   alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  stall_o
);

  localparam int unsigned SH_W   = $clog2(DATA_W);
  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned TRY_W  = DATA_W + 1;

  // Operation encodings shared with the decode stage
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = ALUOP_W'(8'b0000_0000);
  localparam logic [ALUOP_W-1:0] EXE_AND_OP   = ALUOP_W'(8'b0010_0100);
  localparam logic [ALUOP_W-1:0] EXE_OR_OP    = ALUOP_W'(8'b0010_0101);
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = ALUOP_W'(8'b0010_0110);
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = ALUOP_W'(8'b0010_0111);
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = ALUOP_W'(8'b0111_1100);
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = ALUOP_W'(8'b0000_0010);
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = ALUOP_W'(8'b0000_0011);
  localparam logic [ALUOP_W-1:0] EXE_ADDU_OP  = ALUOP_W'(8'b0010_0001);
  localparam logic [ALUOP_W-1:0] EXE_SUBU_OP  = ALUOP_W'(8'b0010_0011);
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP   = ALUOP_W'(8'b0010_1010);
  localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = ALUOP_W'(8'b0001_1001);
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = ALUOP_W'(8'b0001_1011);
  localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = ALUOP_W'(8'b0001_0000);
  localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = ALUOP_W'(8'b0001_0010);

  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = ALUSEL_W'(3'b000);
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = ALUSEL_W'(3'b001);
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = ALUSEL_W'(3'b010);
  localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE  = ALUSEL_W'(3'b011);
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = ALUSEL_W'(3'b100);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  div_state_t          state, state_nxt;
  logic [DATA_W-1:0]   hi, lo;
  logic [DATA_W-1:0]   div_quot;   // dividend shifted out, quotient shifted in
  logic [DATA_W-1:0]   div_rem;
  logic [DATA_W-1:0]   div_dsr;
  logic [CNT_W-1:0]    div_cnt;
  logic                div_start, div_step, div_last, div_commit, stall_c;
  logic [TRY_W-1:0]    div_try;
  logic                div_ge;
  logic [PROD_W-1:0]   prod;
  logic                is_multu, is_divu;
  logic [SH_W-1:0]     shamt;
  logic [DATA_W-1:0]   res_logic, res_shift, res_arith, res_move, result;

  assign is_multu = (aluop_i == EXE_MULTU_OP);
  assign is_divu  = (aluop_i == EXE_DIVU_OP);
  assign shamt    = reg1_i[SH_W-1:0];
  assign prod     = PROD_W'(reg1_i) * PROD_W'(reg2_i);

  // One restoring step: bring in next dividend bit, subtract if it fits
  assign div_try = {div_rem, div_quot[DATA_W-1]};
  assign div_ge  = (div_try >= {1'b0, div_dsr});

  // Divider state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= state_nxt;
  end

  // Divider next state and stall request
  always_comb begin
    state_nxt  = state;
    stall_c    = 1'b0;
    div_start  = 1'b0;
    div_step   = 1'b0;
    div_commit = 1'b0;
    div_last   = (div_cnt == CNT_W'(DATA_W - 1));
    case (state)
      DIV_IDLE: begin
        if (is_divu && !flush_i) begin
          stall_c   = 1'b1;
          div_start = 1'b1;
          state_nxt = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (flush_i) begin
          state_nxt = DIV_IDLE;
        end else begin
          stall_c  = 1'b1;
          div_step = 1'b1;
          if (div_last) state_nxt = DIV_DONE;
        end
      end
      DIV_DONE: begin
        state_nxt = DIV_IDLE;
        if (!flush_i) div_commit = 1'b1;
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  // Divider datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_quot <= '0;
      div_rem  <= '0;
      div_dsr  <= '0;
      div_cnt  <= '0;
    end else if (div_start) begin
      div_quot <= reg1_i;
      div_dsr  <= reg2_i;
      div_rem  <= '0;
      div_cnt  <= '0;
    end else if (div_step) begin
      div_rem  <= div_ge ? DATA_W'(div_try - {1'b0, div_dsr}) : div_try[DATA_W-1:0];
      div_quot <= {div_quot[DATA_W-2:0], div_ge};
      div_cnt  <= div_cnt + CNT_W'(1);
    end
  end

  // HI/LO registers: written by MULTU or a completed divide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_commit) begin
      hi <= div_rem;
      lo <= div_quot;
    end else if (state == DIV_IDLE && is_multu && !flush_i) begin
      hi <= prod[PROD_W-1:DATA_W];
      lo <= prod[DATA_W-1:0];
    end
  end

  // Single-cycle result per class
  always_comb begin
    res_logic = '0;
    res_shift = '0;
    res_arith = '0;
    res_move  = '0;
    case (aluop_i)
      EXE_OR_OP:   res_logic = reg1_i | reg2_i;
      EXE_AND_OP:  res_logic = reg1_i & reg2_i;
      EXE_XOR_OP:  res_logic = reg1_i ^ reg2_i;
      EXE_NOR_OP:  res_logic = ~(reg1_i | reg2_i);
      default:     res_logic = '0;
    endcase
    case (aluop_i)
      EXE_SLL_OP:  res_shift = reg2_i << shamt;
      EXE_SRL_OP:  res_shift = reg2_i >> shamt;
      EXE_SRA_OP:  res_shift = DATA_W'($signed(reg2_i) >>> shamt);
      default:     res_shift = '0;
    endcase
    case (aluop_i)
      EXE_ADDU_OP: res_arith = reg1_i + reg2_i;
      EXE_SUBU_OP: res_arith = reg1_i - reg2_i;
      EXE_SLT_OP:  res_arith = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      default:     res_arith = '0;
    endcase
    case (aluop_i)
      EXE_MFHI_OP: res_move = hi;
      EXE_MFLO_OP: res_move = lo;
      default:     res_move = '0;
    endcase
  end

  // Result class select
  always_comb begin
    result = '0;
    case (alusel_i)
      EXE_RES_LOGIC: result = res_logic;
      EXE_RES_SHIFT: result = res_shift;
      EXE_RES_ARITH: result = res_arith;
      EXE_RES_MOVE:  result = res_move;
      EXE_RES_NOP:   result = '0;
      default:       result = '0;
    endcase
  end

  // Outputs follow decode directly; all forced to zero while in reset
  always_comb begin
    wd_o    = rst ? wd_i : '0;
    wreg_o  = rst && wreg_i && !flush_i && !is_multu && !is_divu;
    wdata_o = rst ? result : '0;
    stall_o = rst && stall_c;
  end

  logic unused_nop;
  assign unused_nop = (aluop_i == EXE_NOP_OP);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed test of ex_muldiv with hand-computed expected values.
module tb_ex_muldiv;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 8;
  localparam int unsigned ALUSEL_W   = 3;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ALUOP_W-1:0]    aluop_i;
  logic [ALUSEL_W-1:0]   alusel_i;
  logic [DATA_W-1:0]     reg1_i, reg2_i;
  logic [REG_ADDR_W-1:0] wd_i;
  logic                  wreg_i, flush_i;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic [DATA_W-1:0]     wdata_o;
  logic                  stall_o;

  int n_chk = 0;
  int n_bad = 0;
  int n_stall;

  ex_muldiv #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)
  ) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  // Count one comparison and report a mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Apply one instruction at the falling edge, settle, leave checking to caller
  task automatic issue(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
    #1;
  endtask

  // Issue DIVU and count stall cycles until the DONE cycle (stall low)
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int cycles);
    issue(OP_DIVU, SEL_NOP, a, b);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (!stall_o) break;
      cycles++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; flush_i = 1'b0; wreg_i = 1'b1; wd_i = 5'd5;
    aluop_i = OP_OR; alusel_i = SEL_LOGIC; reg1_i = 32'h0F0F_0000; reg2_i = 32'h0000_F0F0;
    #3;
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_wreg",  32'(wreg_o), 32'h0);
    check("rst_wd",    32'(wd_o), 32'h0);
    check("rst_stall", 32'(stall_o), 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Logic/shift/arith
    issue(OP_OR, SEL_LOGIC, 32'h0F0F_0000, 32'h0000_F0F0);
    check("or_wdata", wdata_o, 32'h0F0F_F0F0);
    check("or_wd",    32'(wd_o), 32'd5);
    check("or_wreg",  32'(wreg_o), 32'h1);
    check("or_stall", 32'(stall_o), 32'h0);
    issue(OP_XOR, SEL_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0);
    check("xor", wdata_o, 32'hF0F0_F0F0);
    issue(OP_NOR, SEL_LOGIC, 32'h0, 32'h0);
    check("nor", wdata_o, 32'hFFFF_FFFF);
    issue(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0010);
    check("sra", wdata_o, 32'hF800_0001);
    issue(OP_SRL, SEL_SHIFT, 32'd4, 32'h8000_0010);
    check("srl", wdata_o, 32'h0800_0001);
    issue(OP_SLL, SEL_SHIFT, 32'd31, 32'h1);
    check("sll", wdata_o, 32'h8000_0000);
    issue(OP_SLT, SEL_ARITH, 32'hFFFF_FFFF, 32'd1);
    check("slt_true", wdata_o, 32'h1);
    issue(OP_SLT, SEL_ARITH, 32'd1, 32'hFFFF_FFFF);
    check("slt_false", wdata_o, 32'h0);
    issue(OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2);
    check("addu_wrap", wdata_o, 32'h1);
    issue(OP_SUBU, SEL_ARITH, 32'h0, 32'd1);
    check("subu_wrap", wdata_o, 32'hFFFF_FFFF);
    issue(OP_OR, 3'b111, 32'hFFFF_FFFF, 32'h0);
    check("bad_sel", wdata_o, 32'h0);
    issue(OP_ADDU, SEL_LOGIC, 32'h1, 32'h1);
    check("bad_op", wdata_o, 32'h0);
    flush_i = 1'b1; #1;
    check("flush_wreg", 32'(wreg_o), 32'h0);
    flush_i = 1'b0;

    // MULTU then moves
    issue(OP_MULTU, SEL_NOP, 32'hFFFF_FFFF, 32'd2);
    check("multu_wreg",  32'(wreg_o), 32'h0);
    check("multu_stall", 32'(stall_o), 32'h0);
    issue(OP_MFHI, SEL_MOVE, 32'h0, 32'h0);
    check("mul_hi", wdata_o, 32'h1);
    check("mfhi_wreg", 32'(wreg_o), 32'h1);
    issue(OP_MFLO, SEL_MOVE, 32'h0, 32'h0);
    check("mul_lo", wdata_o, 32'hFFFF_FFFE);

    // DIVU 100 / 7
    run_div(32'd100, 32'd7, n_stall);
    check("div_stall_cycles", 32'(n_stall), 32'd33);
    check("div_done_stall", 32'(stall_o), 32'h0);
    check("div_wreg", 32'(wreg_o), 32'h0);
    issue(OP_MFLO, SEL_MOVE, 32'h0, 32'h0);
    check("div_lo", wdata_o, 32'd14);
    check("div_idle_stall", 32'(stall_o), 32'h0);
    issue(OP_MFHI, SEL_MOVE, 32'h0, 32'h0);
    check("div_hi", wdata_o, 32'd2);

    // DIVU by zero
    run_div(32'h1234, 32'h0, n_stall);
    check("div0_stall_cycles", 32'(n_stall), 32'd33);
    issue(OP_MFLO, SEL_MOVE, 32'h0, 32'h0);
    check("div0_lo", wdata_o, 32'hFFFF_FFFF);
    issue(OP_MFHI, SEL_MOVE, 32'h0, 32'h0);
    check("div0_hi", wdata_o, 32'h1234);

    // Flush in BUSY cycle 10
    issue(OP_DIVU, SEL_NOP, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1;
    check("flush_pre_stall", 32'(stall_o), 32'h1);
    flush_i = 1'b1; #1;
    check("flush_stall", 32'(stall_o), 32'h0);
    @(negedge clk);
    flush_i = 1'b0; aluop_i = OP_MFLO; alusel_i = SEL_MOVE; #1;
    check("flush_idle_stall", 32'(stall_o), 32'h0);
    check("flush_lo_kept", wdata_o, 32'hFFFF_FFFF);
    issue(OP_MFHI, SEL_MOVE, 32'h0, 32'h0);
    check("flush_hi_kept", wdata_o, 32'h1234);

    // Reset pulse mid-division
    issue(OP_DIVU, SEL_NOP, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst = 1'b0; #1;
    check("mrst_stall", 32'(stall_o), 32'h0);
    check("mrst_wd",    32'(wd_o), 32'h0);
    check("mrst_wdata", wdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b1; aluop_i = OP_MFLO; alusel_i = SEL_MOVE; #1;
    check("mrst_lo", wdata_o, 32'h0);
    check("mrst_idle_stall", 32'(stall_o), 32'h0);
    issue(OP_MFHI, SEL_MOVE, 32'h0, 32'h0);
    check("mrst_hi", wdata_o, 32'h0);

    issue(OP_NOP, SEL_NOP, 32'h0, 32'h0);
    check("nop", wdata_o, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
